// File: rtl/cnt_event_extract_if.sv
// cnt_event_extract_if: valid/ready event offer carrying the event sequence number.
interface cnt_event_extract_if #(parameter int W = 4);
  logic         ev_valid;
  logic         ev_ready;
  logic [W-1:0] ev_seq;
  modport master (output ev_valid, output ev_seq, input ev_ready);
  modport slave (input ev_valid, input ev_seq, output ev_ready);
endinterface

// File: rtl/cnt_event_extract.sv
// cnt_event_extract: turns increments of a synchronized count into handshaked events.
// Define CNT_EVT_STATS_EN to build the saturating accepted-event counter on ev_total.
module cnt_event_extract #(
  parameter int W        = 4,
  parameter int MAX_STEP = 1
) (
  input  logic                   clk_f,
  input  logic                   rst_n,
  input  logic [W-1:0]           sync_cnt,
  cnt_event_extract_if.master    ev,
  output logic [W-1:0]           pending,
  output logic                   step_err,
  output logic                   ovf_err,
  input  logic                   clr_err,
  output logic [7:0]             ev_total
);
  typedef enum logic [1:0] {INIT, RUN, ERR} state_e;
  localparam logic [W-1:0] MAX_S = W'(MAX_STEP);
  state_e       state_q;
  logic [W-1:0] tgt_q, loc_q, step;
  logic         step_err_q, ovf_err_q, hs, bad_step, ovf;
  always_comb begin
    pending     = tgt_q - loc_q;
    step        = sync_cnt - tgt_q;
    ev.ev_valid = (state_q == RUN) && (pending != '0);
    ev.ev_seq   = loc_q + W'(1);
    hs          = ev.ev_valid & ev.ev_ready;
    bad_step    = step > MAX_S;
    // backlog after this edge, one bit wider so a wrap past 2^W-1 is visible
    ovf         = ({1'b0, pending} + {1'b0, step} - {{W{1'b0}}, hs}) > {1'b0, {W{1'b1}}};
  end
  assign step_err = step_err_q;
  assign ovf_err  = ovf_err_q;
  always_ff @(posedge clk_f) begin
    if (!rst_n) begin
      state_q    <= INIT;
      tgt_q      <= '0;
      loc_q      <= '0;
      step_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          tgt_q   <= sync_cnt;
          loc_q   <= sync_cnt;
          state_q <= RUN;
          if (clr_err) begin
            step_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
          end
        end
        RUN: begin
          tgt_q <= sync_cnt;
          if (bad_step || ovf) begin
            loc_q      <= sync_cnt;
            state_q    <= ERR;
            step_err_q <= bad_step;
            ovf_err_q  <= !bad_step;
          end else begin
            loc_q <= loc_q + W'(hs);
            if (clr_err) begin
              step_err_q <= 1'b0;
              ovf_err_q  <= 1'b0;
            end
          end
        end
        default: begin
          tgt_q <= sync_cnt;
          loc_q <= sync_cnt;
          if (clr_err) begin
            step_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            state_q    <= RUN;
          end
        end
      endcase
    end
  end
`ifdef CNT_EVT_STATS_EN
  logic [7:0] total_q;
  always_ff @(posedge clk_f) begin
    if (!rst_n) total_q <= '0;
    else if (hs && total_q != 8'hff) total_q <= total_q + 8'd1;
  end
  assign ev_total = total_q;
`else
  assign ev_total = '0;
`endif
endmodule

// File: doc/cnt_event_extract.md
CNT_EVENT_EXTRACT -- requirements
Module: cnt_event_extract

Interface
REQ-001 SHALL have parameter W, default 4: width of the synchronized binary count.
REQ-002 SHALL have parameter MAX_STEP, default 1: largest legal per-cycle count increment.
REQ-003 SHALL have port clk_f, input, 1 bit: fast-domain clock; single clock for the whole block.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk_f.
REQ-005 SHALL have port sync_cnt, input, W bits: binary count already gray-decoded and two-flop synchronized into clk_f.
REQ-006 SHALL have port ev_valid, output, 1 bit: one pending event is offered.
REQ-007 SHALL have port ev_ready, input, 1 bit: consumer accepts the offered event.
REQ-008 SHALL have port ev_seq, output, W bits: sequence number of the offered event.
REQ-009 SHALL have port pending, output, W bits: number of unconsumed events.
REQ-010 SHALL have port step_err, output, 1 bit: sticky flag for an illegal count step.
REQ-011 SHALL have port ovf_err, output, 1 bit: sticky flag for pending overflow.
REQ-012 SHALL have port clr_err, input, 1 bit: clears both error flags and resumes operation.
REQ-013 SHALL have port ev_total, output, 8 bits: accepted-event statistic (see Configuration).

Function
REQ-014 SHALL hold registers tgt (last sampled sync_cnt) and loc (last consumed count), both W bits; pending = (tgt - loc) mod 2^W.
REQ-015 SHALL implement FSM states INIT, RUN, ERR; INIT lasts exactly one cycle after reset.
REQ-016 In INIT: tgt <= sync_cnt, loc <= sync_cnt, next state RUN; the count present at reset generates no events.
REQ-017 In RUN each cycle: step = (sync_cnt - tgt) mod 2^W; hs = ev_valid & ev_ready.
REQ-018 In RUN, step <= MAX_STEP: tgt <= sync_cnt; loc <= loc + hs (mod 2^W).
REQ-019 Overflow: when pending + step - hs > 2^W-1 (computed at W+1 bits), ovf_err <= 1 and next state ERR.
REQ-020 Illegal step: when step > MAX_STEP (includes a backward move, seen as a large modular step), step_err <= 1 and next state ERR; step_err takes priority if both conditions hold.
REQ-021 On entry to ERR: tgt <= sync_cnt and loc <= sync_cnt; pending events are discarded.
REQ-022 In ERR: tgt and loc track sync_cnt every cycle; ev_valid = 0.
REQ-023 In ERR with clr_err = 1: step_err <= 0, ovf_err <= 0, next state RUN.
REQ-024 clr_err in INIT or RUN SHALL clear both flags and have no other effect.
REQ-025 ev_valid = (state == RUN) & (pending != 0), decoded from registers only, with no combinational path from ev_ready.
REQ-026 ev_seq = loc + 1 (mod 2^W).
REQ-027 Latency: a sync_cnt increment sampled at edge N raises ev_valid in the cycle after edge N.
REQ-028 Once ev_valid is high it SHALL stay high, with ev_seq stable, until accepted or until the FSM enters ERR.
REQ-029 A simultaneous increment and handshake SHALL give pending' = pending + step - 1.
REQ-030 Count wrap from 2^W-1 to 0 is a legal step of 1.

Reset
REQ-031 rst_n = 0 at a clock edge: state INIT, tgt = 0, loc = 0, step_err = 0, ovf_err = 0, ev_total = 0.
REQ-032 During and after reset, until INIT completes: ev_valid = 0, pending = 0, ev_seq = 1.
REQ-033 Reset asserted mid-operation SHALL discard all pending events with no partial handshake.

Configuration
REQ-034 Macro CNT_EVT_STATS_EN defined: ev_total counts accepted handshakes, saturating at 255, cleared only by reset.
REQ-035 Macro CNT_EVT_STATS_EN undefined: ev_total is tied to 0, no counter logic is built, and the port list is unchanged.

Verification
REQ-036 Reset with sync_cnt = 7, hold 7 -> ev_valid stays 0, pending = 0.
REQ-037 From RUN with tgt = 3 and ev_ready = 1, step sync_cnt 3->4->5 on consecutive cycles -> ev_seq 4 then 5 accepted, each ev_valid one cycle after its increment.
REQ-038 ev_ready = 0, increment 15 times from 0 -> pending = 15, ev_seq = 1; next increment -> ovf_err = 1, ERR, ev_valid = 0.
REQ-039 sync_cnt jumps 5->8 with MAX_STEP = 1 -> step_err = 1, pending = 0; then clr_err = 1 -> RUN, flags 0, next increment yields ev_seq = 9.
REQ-040 Count wrap 15->0 with pending = 1 and a handshake in the same cycle -> pending stays 1, ev_seq = 0.
REQ-041 With CNT_EVT_STATS_EN defined, 300 accepted events -> ev_total = 255; with it undefined -> ev_total = 0.
